// File: rtl/chan_mux_reg.sv
// chan_mux_reg: registered N-channel, WIDTH-bit mux with a one-entry valid/ready output slot.
// Define CHAN_MUX_SCAN_EN to add the auto-scan mode (mode=1) with HOLD-cycle dwell.
module chan_mux_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int HOLD     = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      load,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);
    logic [WIDTH-1:0] data_q, data_d, mux;
    logic [SEL_W-1:0] ochan_q, ochan_d, src;
    logic             valid_q, valid_d, err_q, err_d;
    logic             slot_free, sel_ok, man_en, cap_man, cap_scan, cap, hold_out;

    assign slot_free = !valid_q || out_ready;

`ifdef CHAN_MUX_SCAN_EN
    localparam int DW = HOLD > 1 ? $clog2(HOLD) : 1;
    logic [SEL_W-1:0] chan_cnt_q, chan_cnt_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             mode_q, mode_chg, scan_en, at_end;

    // A mode change burns one cycle: counters restart and the output slot is frozen.
    assign mode_chg = mode != mode_q;
    assign scan_en  = mode_q && !mode_chg;
    assign man_en   = !mode_q && !mode_chg;
    assign hold_out = mode_chg;
    assign at_end   = dwell_q == DW'(HOLD - 1);
    assign cap_scan = scan_en && at_end && slot_free;
    assign src      = scan_en ? chan_cnt_q : sel;

    always_comb begin
        dwell_d    = scan_en ? (at_end ? (slot_free ? '0 : dwell_q) : dwell_q + 1'b1) : '0;
        chan_cnt_d = mode_chg ? '0 :
                     cap_scan ? (chan_cnt_q == SEL_W'(CHANNELS - 1) ? '0 : chan_cnt_q + 1'b1) :
                     chan_cnt_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= 1'b0;
            chan_cnt_q <= '0;
            dwell_q    <= '0;
        end else begin
            mode_q     <= mode;
            chan_cnt_q <= chan_cnt_d;
            dwell_q    <= dwell_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = mode & (HOLD > 0);
    assign man_en     = 1'b1;
    assign hold_out   = 1'b0;
    assign cap_scan   = 1'b0;
    assign src        = sel;
`endif

    // Decode by loop so non-power-of-two CHANNELS never indexes past data_in.
    always_comb begin
        mux    = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(src) == i) mux = data_in[i*WIDTH +: WIDTH];
            if (int'(sel) == i) sel_ok = 1'b1;
        end
    end

    assign cap_man = man_en && load && sel_ok && slot_free;
    assign cap     = cap_man || cap_scan;

    always_comb begin
        err_d   = man_en && load && !sel_ok;
        data_d  = cap ? mux : data_q;
        ochan_d = cap ? src : ochan_q;
        valid_d = cap ? 1'b1 : hold_out ? valid_q : valid_q && !out_ready;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            ochan_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            ochan_q <= ochan_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = ochan_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
endmodule

// File: tb/tb_chan_mux_reg.sv
// tb_chan_mux_reg: scoreboard bench for chan_mux_reg (CHANNELS=4 main DUT, CHANNELS=3 for sel_err).
// Scan checks run when CHAN_MUX_SCAN_EN is defined; otherwise mode=1 must produce no captures.
module tb_chan_mux_reg;
    localparam logic [3:0] A = 4'hA, B = 4'hB, C = 4'hC, D = 4'hD;

    logic        clock = 1'b0, resetn = 1'b0;
    logic [15:0] data_in;
    logic [11:0] data3;
    logic [1:0]  sel = '0, sel1 = '0;
    logic        load = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic        load1 = 1'b0, mode1 = 1'b0, out_ready1 = 1'b0;
    logic [3:0]  out_data, out_data1;
    logic [1:0]  out_chan, out_chan1;
    logic        out_valid, out_valid1, sel_err, sel_err1;
    logic [5:0]  exp_q[$];
    logic [5:0]  e_mon;
    int          tests = 0, fails = 0;

    assign data_in = {D, C, B, A};
    assign data3   = {C, B, A};

    always #5 clock = ~clock;

    chan_mux_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .HOLD(3)) dut0 (
        .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel), .load(load),
        .mode(mode), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    chan_mux_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .HOLD(3)) dut1 (
        .clock(clock), .resetn(resetn), .data_in(data3), .sel(sel1), .load(load1),
        .mode(mode1), .out_data(out_data1), .out_chan(out_chan1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sel_err(sel_err1)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every handshake seen before the coming edge pops one expected sample.
    always @(negedge clock) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_sample: got chan %0d data %0h, expected none", out_chan, out_data);
            end else begin
                e_mon = exp_q.pop_front();
                chk("sample", int'({out_chan, out_data}), int'(e_mon));
            end
        end
    end

    initial begin
        step(2);
        chk("rst_data", int'(out_data), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_err", int'(sel_err), 0);
        resetn = 1'b1;
        step(2);
        chk("idle_valid", int'(out_valid), 0);

        // manual capture, blocked second load, then consume
        sel = 2'd2; load = 1'b1;
        exp_q.push_back({2'd2, C});
        step(1);
        chk("man_valid", int'(out_valid), 1);
        chk("man_data", int'(out_data), int'(C));
        chk("man_chan", int'(out_chan), 2);
        sel = 2'd1;
        step(1);
        chk("drop_chan", int'(out_chan), 2);
        chk("drop_data", int'(out_data), int'(C));
        load = 1'b0; out_ready = 1'b1;
        step(1);
        chk("consume_valid", int'(out_valid), 0);

        // back-to-back, one per cycle
        load = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            exp_q.push_back({2'(s), data_in[s*4 +: 4]});
            step(1);
            chk("b2b_valid", int'(out_valid), 1);
        end
        load = 1'b0;
        step(1);
        chk("b2b_drain", int'(out_valid), 0);
        out_ready = 1'b0;

        // out-of-range select on the 3-channel instance
        sel1 = 2'd0; load1 = 1'b1;
        step(1);
        chk("oor_pre_err", int'(sel_err1), 0);
        chk("oor_pre_data", int'(out_data1), int'(A));
        sel1 = 2'd3;
        step(1);
        chk("oor_err", int'(sel_err1), 1);
        chk("oor_data", int'(out_data1), int'(A));
        chk("oor_valid", int'(out_valid1), 1);
        load1 = 1'b0;
        step(1);
        chk("oor_err_clr", int'(sel_err1), 0);

`ifdef CHAN_MUX_SCAN_EN
        mode = 1'b1; out_ready = 1'b1;
        exp_q.push_back({2'd0, A});
        exp_q.push_back({2'd1, B});
        exp_q.push_back({2'd2, C});
        exp_q.push_back({2'd3, D});
        exp_q.push_back({2'd0, A});
        step(16);
        chk("scan_wrap_chan", int'(out_chan), 0);
        chk("scan_wrap_data", int'(out_data), int'(A));
        out_ready = 1'b0;
        step(6);
        chk("stall_chan", int'(out_chan), 0);
        chk("stall_valid", int'(out_valid), 1);
        exp_q.push_back({2'd1, B});
        out_ready = 1'b1;
        step(1);
        chk("resume_chan", int'(out_chan), 1);
        chk("resume_data", int'(out_data), int'(B));
        step(1);
        mode = 1'b0;
        step(2);
        chk("toggle_valid", int'(out_valid), 0);
        exp_q.push_back({2'd0, A});
        exp_q.push_back({2'd1, B});
        mode = 1'b1;
        step(7);
        chk("restart_chan", int'(out_chan), 1);
        chk("restart_data", int'(out_data), int'(B));
        step(1);
        mode = 1'b0;
        step(3);
`else
        mode = 1'b1; out_ready = 1'b1;
        step(10);
        chk("noscan_valid", int'(out_valid), 0);
        mode = 1'b0;
        step(1);
`endif
        out_ready = 1'b0;

        // reset mid-operation discards the pending sample at once
        sel = 2'd3; load = 1'b1;
        step(1);
        chk("pre_rst_data", int'(out_data), int'(D));
        load = 1'b0; resetn = 1'b0;
        #2;
        chk("async_rst_data", int'(out_data), 0);
        chk("async_rst_chan", int'(out_chan), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        step(1);
        resetn = 1'b1;
        step(2);
        chk("post_rst_valid", int'(out_valid), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
